// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store front end for the 256x32 data block RAM.
// Accepts one request at a time, decodes RISC-V funct3, drives the RAM
// word address, bit mask and lane-replicated write data, and returns
// formatted load data over a valid/ready response channel.
// Optional build macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses fault).
module dmem_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_re,
  output logic [DEPTH_LOG2-1:0] ram_raddr,
  input  logic [31:0]           ram_rdata,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_waddr,
  output logic [31:0]           ram_wdata,
  output logic [31:0]           ram_mask
);

  typedef enum logic [1:0] {IDLE, LOAD_DATA, RESP} state_t;

  state_t      state;
  logic [2:0]  f3_p1;
  logic [1:0]  off_p1;
  logic [31:0] hold_rdata;
  logic        err_q;

  logic        accept;
  logic        range_flt;
  logic        f3_flt;
  logic        align_flt;
  logic        fault;
  logic [3:0]  lane_en;
  logic [31:0] load_fmt;

  // Shift the addressed byte/half down and sign- or zero-extend it.
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] d);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic        [31:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h  = off[1] ? d[31:16] : d[15:0];
    sb = b;
    sh = h;
    case (f3)
      3'b000:  r = 32'(sb);
      3'b001:  r = 32'(sh);
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] store_lanes(input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [3:0] en;
    case (f3[1:0])
      2'b00:   en = 4'b0001 << off;
      2'b01:   en = off[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  // Replicate the store datum so every candidate lane carries it.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  assign range_flt = (req_addr[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2]);

  // Legal funct3 codes differ between loads and stores.
  always_comb begin
    f3_flt = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_flt = 1'b0;
      3'b100, 3'b101:         f3_flt = req_we;
      default:                f3_flt = 1'b1;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfword needs addr[0] clear, word needs addr[1:0] clear.
  always_comb begin
    align_flt = 1'b0;
    case (req_funct3[1:0])
      2'b01:   align_flt = req_addr[0];
      2'b10:   align_flt = |req_addr[1:0];
      default: align_flt = 1'b0;
    endcase
  end
`else
  assign align_flt = 1'b0;
`endif

  assign fault = range_flt | f3_flt | align_flt;

  // RAM side is driven combinationally in the accept cycle.
  assign lane_en   = store_lanes(req_funct3, req_addr[1:0]);
  assign ram_re    = accept & ~req_we & ~fault;
  assign ram_we    = accept &  req_we & ~fault;
  assign ram_raddr = req_addr[DEPTH_LOG2+1:2];
  assign ram_waddr = req_addr[DEPTH_LOG2+1:2];
  assign ram_wdata = store_data(req_funct3, req_wdata);

  // Disabled lanes are masked (mask bit 1 = not written).
  always_comb begin
    ram_mask = '1;
    for (int k = 0; k < 4; k++) begin
      ram_mask[8*k +: 8] = {8{~lane_en[k]}};
    end
  end

  // p0 -> p1: load size/sign and byte offset for the read-data formatter.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_p1  <= req_funct3;
      off_p1 <= req_addr[1:0];
    end
  end

  assign load_fmt = fmt_load(f3_p1, off_p1, ram_rdata);

  // Request/response FSM; the hold register keeps a stalled response stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_rdata <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              hold_rdata <= 32'd0;
              err_q      <= 1'b1;
              state      <= RESP;
            end else if (req_we) begin
              hold_rdata <= 32'd0;
              err_q      <= 1'b0;
              state      <= RESP;
            end else begin
              err_q      <= 1'b0;
              state      <= LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          if (rsp_ready) begin
            state <= IDLE;
          end else begin
            hold_rdata <= load_fmt;
            err_q      <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state != IDLE);
  assign rsp_rdata = (state == LOAD_DATA) ? load_fmt :
                     (state == RESP)      ? hold_rdata : 32'd0;
  assign rsp_err   = (state == RESP) & err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: bench for dmem_ctrl with an attached masked RAM model and a
// byte-addressed reference memory.
module tb_dmem_ctrl;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int WIN_BYTES = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_re;
  logic [7:0]  ram_raddr;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_mask;

  dmem_ctrl #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_mask(ram_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous masked RAM; output wanders on cycles without a read.
  logic [31:0] ram_arr [0:255];
  logic        ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_arr[i] <= 32'd0;
    end else if (ram_we) begin
      for (int k = 0; k < 32; k++)
        if (!ram_mask[k]) ram_arr[ram_waddr][k] <= ram_wdata[k];
    end
    if (ram_re) ram_rdata <= ram_arr[ram_raddr];
    else        ram_rdata <= $urandom;
  end

  int n_total;
  int n_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model: byte array, little-endian, sizes from funct3.
  logic [7:0] ref_mem [0:WIN_BYTES-1];

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    if (a >= 32'(WIN_BYTES)) return 1'b1;
    if (TRAP && (a % 32'(m_size(f3))) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_eff(input logic [2:0] f3, input logic [31:0] a);
    return int'(a % 32'(WIN_BYTES)) & ~(m_size(f3) - 1);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz, e;
    sz = m_size(f3);
    e  = m_eff(f3, a);
    v  = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[e + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  function automatic logic [31:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    int e;
    e = m_eff(f3, a);
    m = 32'hFFFF_FFFF;
    for (int i = 0; i < m_size(f3); i++) m = m & ~(32'hFF << (8 * ((e + i) % 4)));
    return m;
  endfunction

  function automatic logic [31:0] m_ramw(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = m_size(f3);
    if (sz == 1) return {4{wd[7:0]}};
    if (sz == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  task automatic m_commit(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int e;
    if (we && !m_fault(we, f3, a)) begin
      e = m_eff(f3, a);
      for (int i = 0; i < m_size(f3); i++) ref_mem[e + i] = 8'(wd >> (8 * i));
    end
  endtask

  // One full transaction: accept-cycle RAM checks, optional stall, response checks.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int stall, input bit e_err,
                        input logic [31:0] e_rd, input logic [31:0] e_mask,
                        input logic [31:0] e_ramw, input string nm);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    #1;
    chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, ".ram_re"}, 32'(ram_re), 32'(!we && !e_err));
    chk({nm, ".ram_we"}, 32'(ram_we), 32'(we && !e_err));
    if (!e_err && !we) chk({nm, ".raddr"}, 32'(ram_raddr), (a >> 2) & 32'hFF);
    if (!e_err && we) begin
      chk({nm, ".waddr"}, 32'(ram_waddr), (a >> 2) & 32'hFF);
      chk({nm, ".mask"}, ram_mask, e_mask);
      chk({nm, ".wdata"}, ram_wdata, e_ramw);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom_range(0, 255); req_wdata = $urandom;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk({nm, ".stall.valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, ".stall.rdata"}, rsp_rdata, e_rd);
      chk({nm, ".stall.err"}, 32'(rsp_err), 32'(e_err));
      chk({nm, ".stall.req_ready"}, 32'(req_ready), 32'd0);
      chk({nm, ".stall.ram_en"}, {30'd0, ram_re, ram_we}, 32'd0);
      @(posedge clk); #1;
    end
    #1;
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, ".rsp_rdata"}, rsp_rdata, e_rd);
    chk({nm, ".rsp_err"}, 32'(rsp_err), 32'(e_err));
    chk({nm, ".busy_ram_en"}, {30'd0, ram_re, ram_we}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk({nm, ".after.valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".after.req_ready"}, 32'(req_ready), 32'd1);
    m_commit(we, f3, a, wd);
  endtask

  task automatic model_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int stall, input string nm);
    bit e;
    logic [31:0] rd;
    e  = m_fault(we, f3, a);
    rd = (e || we) ? 32'd0 : m_load(f3, a);
    do_req(we, f3, a, wd, stall, e, rd, m_mask(f3, a), m_ramw(f3, wd), nm);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          stall;
    bit          err;
    logic [31:0] rd;
    logic [31:0] mask;
    logic [31:0] ramw;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [2:0]  legal_ld [5];
    n_total = 0; n_pass = 0;
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < WIN_BYTES; i++) ref_mem[i] = 8'd0;
    reset = 1'b1; ram_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; ram_init = 1'b0;
    #1;
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.ram_en", {30'd0, ram_re, ram_we}, 32'd0);

    vecs.push_back('{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 1'b0, 32'h0,          32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        0, 1'b0, 32'hDEADBEEF,   32'h0,        32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'h13,  32'h80,       0, 1'b0, 32'h0,          32'h00FFFFFF, 32'h80808080});
    vecs.push_back('{1'b0, 3'd0, 32'h13,  32'h0,        1, 1'b0, 32'hFFFFFF80,   32'h0,        32'h0});
    vecs.push_back('{1'b0, 3'd4, 32'h13,  32'h0,        0, 1'b0, 32'h00000080,   32'h0,        32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        0, 1'b0, 32'h80ADBEEF,   32'h0,        32'h0});
    vecs.push_back('{1'b1, 3'd2, 32'h10,  32'h80017FFF, 0, 1'b0, 32'h0,          32'h0,        32'h80017FFF});
    vecs.push_back('{1'b0, 3'd1, 32'h12,  32'h0,        0, 1'b0, 32'hFFFF8001,   32'h0,        32'h0});
    vecs.push_back('{1'b0, 3'd5, 32'h10,  32'h0,        0, 1'b0, 32'h00007FFF,   32'h0,        32'h0});
    vecs.push_back('{1'b1, 3'd2, 32'h20,  32'h12345678, 0, 1'b0, 32'h0,          32'h0,        32'h12345678});
    vecs.push_back('{1'b0, 3'd2, 32'h20,  32'h0,        3, 1'b0, 32'h12345678,   32'h0,        32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h400, 32'h0,        0, 1'b1, 32'h0,          32'h0,        32'h0});
    vecs.push_back('{1'b0, 3'd3, 32'h10,  32'h0,        0, 1'b1, 32'h0,          32'h0,        32'h0});
    vecs.push_back('{1'b1, 3'd4, 32'h10,  32'hFFFFFFFF, 1, 1'b1, 32'h0,          32'h0,        32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'h11,  32'hABCD,     0, TRAP, 32'h0,          32'hFFFF0000, 32'hABCDABCD});
    vecs.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        0, 1'b0, TRAP ? 32'h80017FFF : 32'h8001ABCD, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h13,  32'h0,        0, TRAP, TRAP ? 32'h0 : 32'h8001ABCD,        32'h0, 32'h0});
    vecs.push_back('{1'b0, 3'd0, 32'h11,  32'h0,        2, 1'b0, TRAP ? 32'h0000007F : 32'hFFFFFFAB, 32'h0, 32'h0});

    foreach (vecs[i])
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].stall,
             vecs[i].err, vecs[i].rd, vecs[i].mask, vecs[i].ramw, $sformatf("vec%0d", i));

    // Reset while a load response is pending.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk("rst_load.pending", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_load.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_load.req_ready", 32'(req_ready), 32'd1);
    chk("rst_load.rsp_err", 32'(rsp_err), 32'd0);

    // Reset while a store ack is pending; the write must persist.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_commit(1'b1, 3'd2, 32'h30, 32'hCAFEF00D);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_store.rsp_valid", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'd2, 32'h30, 32'h0, 0, 1'b0, 32'hCAFEF00D, 32'h0, 32'h0, "rst_store.readback");

    for (int n = 0; n < 200; n++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_we)                 r_f3 = 3'($urandom_range(0, 2));
      else                           r_f3 = legal_ld[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       r_a = 32'h400 + 32'($urandom_range(0, 4095));
        1:       r_a = $urandom;
        default: r_a = 32'($urandom_range(0, 63));
      endcase
      r_wd = $urandom;
      model_req(r_we, r_f3, r_a, r_wd, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
